// File: rtl/mem_responder.sv
// mem_responder: memory-side endpoint for the cache controller's word request
// interface. It accepts one request at a time from IDLE. A write lands in the
// internal RAM on its accept edge and is acknowledged by holding rdy low for
// WRITE_ACK_CYCLES cycles. A read waits READ_LATENCY cycles and then streams
// a wrapping burst of max(len,1) words, one beat per cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   i_mem_req    request strobe, sampled only while idle with rdy high
//   i_mem_addr   byte address; the sub-word bits are ignored
//   i_mem_wen    1 = write, 0 = read
//   i_mem_ben    per-byte write enables
//   i_mem_len    read burst length in beats (0 is treated as 1)
//   i_mem_data   write data
//   o_mem_rdy    idle and ready; falling edge acknowledges the request
//   o_mem_valid  read beat valid
//   o_mem_data   read beat data, held while valid is low
module mem_responder #(
  parameter int ADDR_WIDTH       = 10,
  parameter int DATA_WIDTH       = 32,
  parameter int READ_LATENCY     = 2,
  parameter int WRITE_ACK_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_mem_req,
  input  logic [ADDR_WIDTH-1:0]   i_mem_addr,
  input  logic                    i_mem_wen,
  input  logic [DATA_WIDTH/8-1:0] i_mem_ben,
  input  logic [7:0]              i_mem_len,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  output logic                    o_mem_rdy,
  output logic                    o_mem_valid,
  output logic [DATA_WIDTH-1:0]   o_mem_data
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int WORD_LSB = $clog2(NB);
  localparam int IDX_W    = ADDR_WIDTH - WORD_LSB;
  localparam int DEPTH    = 1 << IDX_W;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ_WAIT,
    S_READ_BURST
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              left_q, left_d;
  logic                    rdy_q, rdy_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    we;
  logic                    accept;
  logic [IDX_W-1:0]        req_idx;

  // Backing store: zero at power-up, deliberately untouched by reset.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH] = '{default: '0};

  assign req_idx = i_mem_addr[ADDR_WIDTH-1:WORD_LSB];

  generate
    if (WORD_LSB > 0) begin : g_unused_lsb
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^i_mem_addr[WORD_LSB-1:0];
    end
  endgenerate

  // rdy_q also gates acceptance so the cycle right after reset, where the
  // state is already IDLE but rdy is still low, never accepts a request.
  assign accept = (state_q == S_IDLE) && rdy_q && i_mem_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    left_d  = left_q;
    rdy_d   = rdy_q;
    valid_d = 1'b0;
    data_d  = data_q;
    we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          rdy_d = 1'b0;
          idx_d = req_idx;
          if (i_mem_wen) begin
            we      = 1'b1;
            cnt_d   = CNT_W'(WRITE_ACK_CYCLES - 1);
            state_d = S_WRITE;
          end else begin
            cnt_d   = CNT_W'(READ_LATENCY - 1);
            // left counts beats remaining after the first one.
            left_d  = (i_mem_len == 8'd0) ? 8'd0 : i_mem_len - 8'd1;
            state_d = S_READ_WAIT;
          end
        end
      end

      S_WRITE: begin
        if (cnt_q == '0) begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_READ_WAIT: begin
        if (cnt_q == '0) begin
          valid_d = 1'b1;
          data_d  = mem_q[idx_q];
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_READ_BURST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_READ_BURST: begin
        if (left_q == 8'd0) begin
          // valid low together with rdy high marks burst completion.
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
          data_d  = mem_q[idx_q];
          idx_d   = idx_q + IDX_W'(1);
          left_d  = left_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      rdy_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      rdy_q   <= rdy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Byte-enabled write commits on the accept edge.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      for (int i = 0; i < NB; i++) begin
        if (i_mem_ben[i]) begin
          mem_q[req_idx][8*i +: 8] <= i_mem_data[8*i +: 8];
        end
      end
    end
  end

  assign o_mem_rdy   = rdy_q;
  assign o_mem_valid = valid_q;
  assign o_mem_data  = data_q;

endmodule
